// File: rtl/pipe_hazard_ctrl.sv
// Hazard and redirect controller for the 5-stage RV32I pipeline: PC/IF-ID holds, flushes, redirects, halt.
// Optional performance counters are built when PIPE_CTRL_PERF_EN is defined.
module pipe_hazard_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             isBranch_E,
  input  logic [31:0]      PC_IMM_E,
  input  logic             MemRead_E,
  input  logic [4:0]       RD_E,
  input  logic [4:0]       RS1_D,
  input  logic [4:0]       RS2_D,
  input  logic             USE_RS1_D,
  input  logic             USE_RS2_D,
  input  logic             IMEM_RDY,
  input  logic             HALT_REQ,
  input  logic             RESUME,
  output logic             STALL_PC,
  output logic             STALL_FD,
  output logic             FLUSH_FD,
  output logic             FLUSH_DE,
  output logic             REDIRECT,
  output logic [31:0]      REDIRECT_PC,
  output logic             HALTED,
  output logic [CNT_W-1:0] CNT_STALL,
  output logic [CNT_W-1:0] CNT_REDIR
);

  typedef enum logic [1:0] {
    S_RUN        = 2'd0,
    S_REDIR_PEND = 2'd1,
    S_HALT       = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pend_pc_q, pend_pc_d;
  logic        load_use;

  assign load_use = MemRead_E && (RD_E != 5'd0) &&
                    ((USE_RS1_D && (RS1_D == RD_E)) || (USE_RS2_D && (RS2_D == RD_E)));

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= S_RUN;
      pend_pc_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      pend_pc_q <= pend_pc_d;
    end
  end

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    pend_pc_d   = pend_pc_q;
    STALL_PC    = 1'b0;
    STALL_FD    = 1'b0;
    FLUSH_FD    = 1'b0;
    FLUSH_DE    = 1'b0;
    REDIRECT    = 1'b0;
    REDIRECT_PC = 32'd0;
    HALTED      = 1'b0;
    // Outputs stay quiet for the whole time reset is held.
    if (!RST) begin
      unique case (state_q)
        S_RUN: begin
          REDIRECT_PC = PC_IMM_E;
          if (isBranch_E) begin
            FLUSH_FD = 1'b1;
            FLUSH_DE = 1'b1;
            if (IMEM_RDY) begin
              REDIRECT = 1'b1;
            end else begin
              STALL_PC  = 1'b1;
              pend_pc_d = PC_IMM_E;
              state_d   = S_REDIR_PEND;
            end
          end else if (HALT_REQ) begin
            STALL_PC = 1'b1;
            STALL_FD = 1'b1;
            FLUSH_DE = 1'b1;
            state_d  = S_HALT;
          end else if (load_use) begin
            STALL_PC = 1'b1;
            STALL_FD = 1'b1;
            FLUSH_DE = 1'b1;
          end else if (!IMEM_RDY) begin
            STALL_PC = 1'b1;
            FLUSH_FD = 1'b1;
          end
        end
        S_REDIR_PEND: begin
          // The fetch completing here is still wrong-path, so it is flushed too.
          REDIRECT_PC = pend_pc_q;
          FLUSH_FD    = 1'b1;
          FLUSH_DE    = 1'b1;
          if (IMEM_RDY) begin
            REDIRECT = 1'b1;
            state_d  = S_RUN;
          end else begin
            STALL_PC = 1'b1;
          end
        end
        S_HALT: begin
          STALL_PC = 1'b1;
          STALL_FD = 1'b1;
          FLUSH_DE = 1'b1;
          HALTED   = 1'b1;
          if (RESUME) state_d = S_RUN;
        end
        default: state_d = S_RUN;
      endcase
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  logic [CNT_W-1:0] cnt_stall_q, cnt_redir_q;
  logic             stall_cnt_en;

  // Halt-entry and halted cycles are not counted as stalls.
  assign stall_cnt_en = STALL_PC && (state_q != S_HALT) && (state_d != S_HALT);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_stall_q <= '0;
      cnt_redir_q <= '0;
    end else begin
      if (stall_cnt_en) cnt_stall_q <= cnt_stall_q + 1'b1;
      if (REDIRECT)     cnt_redir_q <= cnt_redir_q + 1'b1;
    end
  end

  assign CNT_STALL = cnt_stall_q;
  assign CNT_REDIR = cnt_redir_q;
`else
  assign CNT_STALL = '0;
  assign CNT_REDIR = '0;
`endif

  // EX holds a bubble while a redirect is pending, so no branch or halt may resolve.
  a_pend_quiet_ex: assert property (@(posedge CLK) disable iff (RST)
    (state_q == S_REDIR_PEND) |-> !(isBranch_E || HALT_REQ));

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed test-plan steps, then random cycles against
// a behavioural model (halt flag plus a queue of pending redirect targets).
module tb_pipe_hazard_ctrl;

  localparam int CNT_W = 32;

  logic             CLK = 1'b0;
  logic             RST;
  logic             isBranch_E, MemRead_E, USE_RS1_D, USE_RS2_D, IMEM_RDY, HALT_REQ, RESUME;
  logic [31:0]      PC_IMM_E;
  logic [4:0]       RD_E, RS1_D, RS2_D;
  logic             STALL_PC, STALL_FD, FLUSH_FD, FLUSH_DE, REDIRECT, HALTED;
  logic [31:0]      REDIRECT_PC;
  logic [CNT_W-1:0] CNT_STALL, CNT_REDIR;

  pipe_hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .CLK(CLK), .RST(RST), .isBranch_E(isBranch_E), .PC_IMM_E(PC_IMM_E),
    .MemRead_E(MemRead_E), .RD_E(RD_E), .RS1_D(RS1_D), .RS2_D(RS2_D),
    .USE_RS1_D(USE_RS1_D), .USE_RS2_D(USE_RS2_D), .IMEM_RDY(IMEM_RDY),
    .HALT_REQ(HALT_REQ), .RESUME(RESUME), .STALL_PC(STALL_PC), .STALL_FD(STALL_FD),
    .FLUSH_FD(FLUSH_FD), .FLUSH_DE(FLUSH_DE), .REDIRECT(REDIRECT),
    .REDIRECT_PC(REDIRECT_PC), .HALTED(HALTED), .CNT_STALL(CNT_STALL), .CNT_REDIR(CNT_REDIR)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic        stall_pc;
    logic        stall_fd;
    logic        flush_fd;
    logic        flush_de;
    logic        redirect;
    logic [31:0] rpc;
    logic        halted;
  } ctl_t;

  int               total = 0;
  int               bad   = 0;
  bit               m_halt;
  logic [31:0]      m_pend[$];
  logic [CNT_W-1:0] m_cs, m_cr;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit hazard();
    return MemRead_E && RD_E != 0 &&
           ((USE_RS1_D && RS1_D == RD_E) || (USE_RS2_D && RS2_D == RD_E));
  endfunction

  function automatic ctl_t model_out();
    ctl_t e = '0;
    if (RST) return e;
    if (m_halt) begin
      e.stall_pc = 1; e.stall_fd = 1; e.flush_de = 1; e.halted = 1;
    end else if (m_pend.size() != 0) begin
      e.rpc = m_pend[0]; e.flush_fd = 1; e.flush_de = 1;
      if (IMEM_RDY) e.redirect = 1; else e.stall_pc = 1;
    end else begin
      e.rpc = PC_IMM_E;
      if (isBranch_E) begin
        e.flush_fd = 1; e.flush_de = 1;
        if (IMEM_RDY) e.redirect = 1; else e.stall_pc = 1;
      end else if (HALT_REQ) begin
        e.stall_pc = 1; e.stall_fd = 1; e.flush_de = 1;
      end else if (hazard()) begin
        e.stall_pc = 1; e.stall_fd = 1; e.flush_de = 1;
      end else if (!IMEM_RDY) begin
        e.stall_pc = 1; e.flush_fd = 1;
      end
    end
    return e;
  endfunction

  task automatic model_update(input ctl_t e);
    bit entering_halt;
    if (RST) return;
    entering_halt = !m_halt && m_pend.size() == 0 && !isBranch_E && HALT_REQ;
    if (e.stall_pc && !m_halt && !entering_halt) m_cs++;
    if (e.redirect) m_cr++;
    if (m_halt) begin
      if (RESUME) m_halt = 0;
    end else if (m_pend.size() != 0) begin
      if (IMEM_RDY) void'(m_pend.pop_front());
    end else if (isBranch_E) begin
      if (!IMEM_RDY) m_pend.push_back(PC_IMM_E);
    end else if (HALT_REQ) begin
      m_halt = 1;
    end
  endtask

  // Inputs are set at the negedge; outputs are checked 1 ns later, the model advances at posedge.
  task automatic step(input string tag);
    ctl_t             e;
    logic [63:0]      cnt_exp;
    #1;
    if (RST) begin
      m_halt = 0; m_pend.delete(); m_cs = '0; m_cr = '0;
    end
    e = model_out();
    check({tag, "/ctl"}, 64'({STALL_PC, STALL_FD, FLUSH_FD, FLUSH_DE, REDIRECT, REDIRECT_PC, HALTED}),
          64'(e));
`ifdef PIPE_CTRL_PERF_EN
    cnt_exp = {m_cs, m_cr};
`else
    cnt_exp = 64'd0;
`endif
    check({tag, "/cnt"}, {CNT_STALL, CNT_REDIR}, cnt_exp);
    check({tag, "/fd_excl"}, 64'(STALL_FD & FLUSH_FD), 64'd0);
    @(posedge CLK);
    model_update(e);
    @(negedge CLK);
  endtask

  task automatic quiet();
    isBranch_E = 0; PC_IMM_E = 32'h0; MemRead_E = 0; RD_E = 0; RS1_D = 0; RS2_D = 0;
    USE_RS1_D = 0; USE_RS2_D = 0; IMEM_RDY = 1; HALT_REQ = 0; RESUME = 0;
  endtask

  initial begin
    RST = 1;
    quiet();
    m_halt = 0; m_cs = '0; m_cr = '0;
    @(negedge CLK);
    // Busy inputs during reset must still give all-zero outputs.
    isBranch_E = 1; PC_IMM_E = 32'h55; HALT_REQ = 1; IMEM_RDY = 0;
    step("reset");
    RST = 0;
    quiet();
    step("idle");

    isBranch_E = 1; PC_IMM_E = 32'h100; MemRead_E = 1; RD_E = 5'd7; RS1_D = 5'd7; USE_RS1_D = 1;
    step("br_hit_with_lu");
    quiet();
    step("after_br_hit");

    isBranch_E = 1; PC_IMM_E = 32'h200; IMEM_RDY = 0;
    step("br_wait0");
    isBranch_E = 0; PC_IMM_E = 32'h0;
    for (int i = 0; i < 3; i++) step("br_pend");
    IMEM_RDY = 1;
    step("br_pend_done");
    step("after_pend");

    MemRead_E = 1; RD_E = 5'd5; RS2_D = 5'd5; USE_RS2_D = 1;
    step("load_use");
    MemRead_E = 0;
    step("load_use_bubble");
    MemRead_E = 1; RD_E = 5'd0; RS2_D = 5'd0;
    step("load_use_x0");
    RD_E = 5'd5; RS2_D = 5'd5; IMEM_RDY = 0;
    step("load_use_imem_wait");
    quiet();
    IMEM_RDY = 0;
    step("imem_wait");
    quiet();

    HALT_REQ = 1;
    step("halt_req");
    HALT_REQ = 0;
    for (int i = 0; i < 10; i++) step("halted");
    RESUME = 1;
    step("resume");
    RESUME = 0;
    step("after_resume");

    isBranch_E = 1; PC_IMM_E = 32'h300; IMEM_RDY = 0;
    step("rst_br_wait");
    isBranch_E = 0;
    step("rst_pend");
    RST = 1;
    step("rst_in_pend");
    RST = 0;
    IMEM_RDY = 1; PC_IMM_E = 32'h44;
    step("no_redirect_after_rst");
    isBranch_E = 1; PC_IMM_E = 32'h400;
    step("br_after_rst");
    quiet();
    step("cnt_one_redirect");

    for (int i = 0; i < 400; i++) begin
      bit pending;
      pending = (m_pend.size() != 0);
      isBranch_E = !pending && ($urandom_range(0, 5) == 0);
      HALT_REQ   = !pending && ($urandom_range(0, 19) == 0);
      PC_IMM_E   = $urandom;
      MemRead_E  = $urandom_range(0, 1) == 1;
      RD_E       = 5'($urandom_range(0, 3));
      RS1_D      = 5'($urandom_range(0, 3));
      RS2_D      = 5'($urandom_range(0, 3));
      USE_RS1_D  = $urandom_range(0, 1) == 1;
      USE_RS2_D  = $urandom_range(0, 1) == 1;
      IMEM_RDY   = $urandom_range(0, 2) != 0;
      RESUME     = $urandom_range(0, 3) == 0;
      step("random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
